enigma_param: RTL and testbench



---
 rtl/enigma_pkg.sv | 37 +++
 rtl/enigma_rotor_b_perm.sv | 25 ++
 rtl/enigma_param.sv | 142 ++++++++++++++
 tb/tb_enigma_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the parametrised two-rotor Enigma cipher.
//   state_t     : controller states (IDLE, LOAD, READY)
//   SRC         : rotor-B in-group offset permutation, indexed SRC[m][j]
//   inv_lookup  : reverse table search used on the return path
package enigma_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    localparam int MAX_N = 256;
    typedef logic [7:0] sym_t;
    typedef sym_t [MAX_N-1:0] lut_t;

    // Packed so that SRC[m][j] reads naturally; each row literal lists
    // offsets j=7 down to j=0.
    localparam logic [7:0][7:0][2:0] SRC = {
        24'o01234567,   // m7: 7 6 5 4 3 2 1 0
        24'o10452376,   // m6: 6 7 3 2 5 4 0 1
        24'o21043765,   // m5: 5 6 7 3 4 0 1 2
        24'o32107654,   // m4: 4 5 6 7 0 1 2 3
        24'o73216540,   // m3: 0 4 5 6 1 2 3 7
        24'o54761032,   // m2: 2 3 0 1 6 7 4 5
        24'o67452301,   // m1: 1 0 3 2 5 4 7 6
        24'o76543210    // m0: 0 1 2 3 4 5 6 7
    };

    // Lowest index i < n with t[i] == v, or 0 when v is absent.
    // Scanning downwards lets the lowest match overwrite higher ones.
    function automatic sym_t inv_lookup(input lut_t t, input int n, input sym_t v);
        sym_t r;
        r = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n && t[i] == v) r = sym_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/enigma_rotor_b_perm.sv
// Combinational rotor-B step: every group of eight entries is reordered by
// the SRC row selected by m.
//   b_cur  : current rotor-B table
//   m      : permutation mode (0..7)
//   b_next : stepped rotor-B table
module enigma_rotor_b_perm
    import enigma_pkg::*;
#(
    parameter int SYM_W = 6
) (
    input  logic [2**SYM_W-1:0][SYM_W-1:0] b_cur,
    input  logic [2:0]                     m,
    output logic [2**SYM_W-1:0][SYM_W-1:0] b_next
);
    localparam int N = 2**SYM_W;

    always_comb begin
        b_next = b_cur;
        for (int g = 0; g < N / 8; g++) begin
            for (int j = 0; j < 8; j++) begin
                b_next[8*g + j] = b_cur[8*g + int'(SRC[m][j])];
            end
        end
    end
endmodule

// File: rtl/enigma_param.sv
// Two-rotor Enigma cipher with loadable rotor tables.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : table load word valid; 2N consecutive words fill A then B
//   in_valid_2    : message symbol valid (accepted only in READY)
//   crypt_mode    : 0 encrypt / 1 decrypt, captured with the first load word
//   rewind        : restore rotors to their post-load snapshot
//   code_in       : load word or message symbol
//   ready         : controller is in READY
//   load_err      : sticky flag, set when a load burst ends early
//   out_valid     : out_code carries a result (two cycles after input)
//   out_code      : cipher result, zero when out_valid is low
module enigma_param
    import enigma_pkg::*;
#(
    parameter int SYM_W   = 6,
    parameter int SHIFT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_valid_2,
    input  logic             crypt_mode,
    input  logic             rewind,
    input  logic [SYM_W-1:0] code_in,
    output logic             ready,
    output logic             load_err,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_code
);
    localparam int N = 2**SYM_W;

    typedef logic [N-1:0][SYM_W-1:0] tab_t;

    state_t           state;
    logic [SYM_W:0]   cnt;
    logic             crypt;
    logic             s1_valid;
    logic [SYM_W-1:0] x;
    tab_t             a_tab, b_tab, a_shd, b_shd;
    tab_t             a_step, b_step;
    lut_t             a_lut, b_lut;
    logic [SYM_W-1:0] a_v, b_v, r_v, c_v, y_v;
    logic [SHIFT_W-1:0] s_v;
    logic [2:0]       m_v;

    always_comb begin
        a_lut = '0;
        b_lut = '0;
        for (int i = 0; i < N; i++) begin
            a_lut[i] = sym_t'(a_tab[i]);
            b_lut[i] = sym_t'(b_tab[i]);
        end
        a_v = a_tab[x];
        b_v = b_tab[a_v];
        r_v = ~b_v;                          // N-1-b in SYM_W bits
        c_v = SYM_W'(inv_lookup(b_lut, N, sym_t'(r_v)));
        y_v = SYM_W'(inv_lookup(a_lut, N, sym_t'(c_v)));
        // Decrypt steps from the mirrored intermediates so the machine is self-inverse.
        s_v = crypt ? c_v[SHIFT_W-1:0] : a_v[SHIFT_W-1:0];
        m_v = crypt ? r_v[2:0] : b_v[2:0];
        for (int i = 0; i < N; i++) begin
            a_step[i] = a_tab[SYM_W'(i) - SYM_W'(s_v)];
        end
    end

    enigma_rotor_b_perm #(.SYM_W(SYM_W)) u_b_perm (
        .b_cur  (b_tab),
        .m      (m_v),
        .b_next (b_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            crypt     <= 1'b0;
            s1_valid  <= 1'b0;
            x         <= '0;
            ready     <= 1'b0;
            load_err  <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= '0;
            for (int i = 0; i < N; i++) begin
                a_tab[i] <= SYM_W'(i);
                b_tab[i] <= SYM_W'(i);
                a_shd[i] <= SYM_W'(i);
                b_shd[i] <= SYM_W'(i);
            end
        end else begin
            out_valid <= s1_valid;
            out_code  <= s1_valid ? y_v : '0;
            s1_valid  <= 1'b0;

            if (s1_valid) begin
                a_tab <= a_step;
                b_tab <= b_step;
            end else if (state == READY && rewind && !in_valid_2) begin
                a_tab <= a_shd;
                b_tab <= b_shd;
            end

            // Load writes come last so a word landing on the same edge as a
            // rotor step or rewind takes precedence for its entry.
            case (state)
                IDLE, READY: begin
                    if (in_valid) begin
                        a_tab[0] <= code_in;
                        crypt    <= crypt_mode;
                        load_err <= 1'b0;
                        cnt      <= (SYM_W+1)'(1);
                        state    <= LOAD;
                        ready    <= 1'b0;
                    end else if (state == READY && in_valid_2) begin
                        x        <= code_in;
                        s1_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (!cnt[SYM_W]) a_tab[cnt[SYM_W-1:0]] <= code_in;
                        else             b_tab[cnt[SYM_W-1:0]] <= code_in;
                        if (cnt == {(SYM_W+1){1'b1}}) begin
                            a_shd        <= a_tab;
                            b_shd        <= b_tab;
                            b_shd[N-1]   <= code_in;
                            cnt          <= '0;
                            state        <= READY;
                            ready        <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        load_err <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_param.sv
module tb_enigma_param;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_valid_2, crypt_mode, rewind;
    logic [5:0] code_in;
    logic       ready, load_err, out_valid;
    logic [5:0] out_code;

    logic       rst4, in_valid4, in_valid_24, crypt_mode4, rewind4;
    logic [3:0] code_in4;
    logic       ready4, load_err4, out_valid4;
    logic [3:0] out_code4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$], due_q[$], exp4_q[$], due4_q[$];
    int mon_e, mon_d, mon4_e, mon4_d;

    enigma_param #(.SYM_W(6), .SHIFT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid_2(in_valid_2),
        .crypt_mode(crypt_mode), .rewind(rewind), .code_in(code_in),
        .ready(ready), .load_err(load_err), .out_valid(out_valid), .out_code(out_code)
    );

    enigma_param #(.SYM_W(4), .SHIFT_W(1)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_valid_2(in_valid_24),
        .crypt_mode(crypt_mode4), .rewind(rewind4), .code_in(code_in4),
        .ready(ready4), .load_err(load_err4), .out_valid(out_valid4), .out_code(out_code4)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out", int'(out_code), -1);
            else begin
                mon_e = exp_q.pop_front();
                mon_d = due_q.pop_front();
                check("out_code", int'(out_code), mon_e);
                check("latency_cycle", cyc, mon_d);
            end
        end else if (out_code != 0) check("out_code_idle", int'(out_code), 0);
        if (out_valid4) begin
            if (exp4_q.size() == 0) check("unexpected_out4", int'(out_code4), -1);
            else begin
                mon4_e = exp4_q.pop_front();
                mon4_d = due4_q.pop_front();
                check("out_code4", int'(out_code4), mon4_e);
                check("latency_cycle4", cyc, mon4_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pattern 0: identity A and B; pattern 1: A[k]=k+1 mod 64, B identity
    function automatic logic [5:0] load_word(input int pattern, input int k);
        if (k < 64) return (pattern == 1) ? 6'((k + 1) % 64) : 6'(k);
        return 6'(k - 64);
    endfunction

    task automatic load_words(input int pattern, input logic mode, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            in_valid   = 1'b1;
            crypt_mode = mode;
            code_in    = load_word(pattern, k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_sym(input int code, input int want);
        code_in    = 6'(code);
        in_valid_2 = 1'b1;
        exp_q.push_back(want);
        due_q.push_back(cyc + 2);
        tick();
        in_valid_2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_valid_2 = 0; crypt_mode = 0; rewind = 0; code_in = '0;
        rst4 = 1'b1; in_valid4 = 0; in_valid_24 = 0; crypt_mode4 = 0; rewind4 = 0; code_in4 = '0;
        idle(2);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_load_err", int'(load_err), 0);
        check("rst_a5", int'(dut.a_tab[5]), 5);
        rst = 1'b0; rst4 = 1'b0;
        idle(1);

        // identity tables, encrypt
        load_words(0, 1'b0, 0, 128);
        check("ready_after_load", int'(ready), 1);
        send_sym(5, 58);
        send_sym(0, 1);
        check("a_step0", int'(dut.a_tab[0]), 63);
        check("b_step0", int'(dut.b_tab[0]), 5);
        check("b_step1", int'(dut.b_tab[1]), 6);
        check("b_step3", int'(dut.b_tab[3]), 3);
        check("b_step5", int'(dut.b_tab[5]), 0);
        check("b_step7", int'(dut.b_tab[7]), 2);
        idle(3);

        // rewind restores the snapshot; rewind with a symbol is ignored
        rewind = 1'b1; tick(); rewind = 1'b0;
        send_sym(5, 58);
        send_sym(0, 1);
        idle(3);
        rewind = 1'b1;
        send_sym(5, 2);
        rewind = 1'b0;
        idle(3);

        // identity tables, decrypt
        load_words(0, 1'b1, 0, 128);
        send_sym(58, 5);
        send_sym(1, 0);
        idle(3);

        // interrupted load, then full reload with rotated A
        load_words(1, 1'b0, 0, 70);
        tick();
        check("err_after_cut", int'(load_err), 1);
        check("ready_after_cut", int'(ready), 0);
        code_in = 6'd5; in_valid_2 = 1'b1; idle(2); in_valid_2 = 1'b0;
        idle(2);
        load_words(1, 1'b0, 0, 1);
        check("err_clear_first_word", int'(load_err), 0);
        load_words(1, 1'b0, 1, 126);
        check("ready_before_last", int'(ready), 0);
        load_words(1, 1'b0, 127, 1);
        check("ready_after_last", int'(ready), 1);
        send_sym(5, 56);
        idle(3);

        // in_valid beats in_valid_2: symbol dropped, load restarts
        in_valid = 1'b1; in_valid_2 = 1'b1; code_in = 6'd5;
        tick();
        in_valid = 1'b0; in_valid_2 = 1'b0;
        check("ready_on_restart", int'(ready), 0);
        tick();
        check("err_on_restart_cut", int'(load_err), 1);
        idle(3);

        // reset mid-message
        load_words(0, 1'b0, 0, 128);
        send_sym(5, 58);
        code_in = 6'd0; in_valid_2 = 1'b1;
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_ready", int'(ready), 0);
        check("rst_mid_a0", int'(dut.a_tab[0]), 0);
        check("rst_mid_b0", int'(dut.b_tab[0]), 0);
        in_valid_2 = 1'b0;
        tick();
        rst = 1'b0;
        idle(4);

        // SYM_W=4, SHIFT_W=1, identity tables, encrypt 3
        for (int k = 0; k < 32; k++) begin
            in_valid4 = 1'b1; crypt_mode4 = 1'b0; code_in4 = 4'(k % 16);
            tick();
        end
        in_valid4 = 1'b0;
        check("ready4", int'(ready4), 1);
        code_in4 = 4'd3; in_valid_24 = 1'b1;
        exp4_q.push_back(12); due4_q.push_back(cyc + 2);
        tick();
        in_valid_24 = 1'b0;
        tick();
        check("a4_step0", int'(dut4.a_tab[0]), 15);
        check("a4_step1", int'(dut4.a_tab[1]), 0);
        check("b4_step1", int'(dut4.b_tab[1]), 4);
        check("b4_step4", int'(dut4.b_tab[4]), 1);
        check("b4_step9", int'(dut4.b_tab[9]), 12);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        check("queue4_drained", exp4_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
